// File: rtl/bias_add_argmax.sv
// bias_add_argmax: adds per-class bias to accumulated scores and reports the argmax class and score.
// Optional feature: define BIAS_ADD_SAT_EN to saturate the biased sum instead of wrapping it.
module bias_add_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 4,
    parameter int ACC_W       = 24,
    parameter int BIAS_W      = 8,
    parameter int BIAS_SHIFT  = 0
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic [IDX_W-1:0]         rom_addr_o,
    input  logic signed [BIAS_W-1:0] bias_i,
    input  logic                     acc_valid_i,
    input  logic signed [ACC_W-1:0]  acc_i,
    output logic                     acc_ready_o,
    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic [IDX_W-1:0]         class_o,
    output logic signed [ACC_W-1:0]  score_o
);
    typedef enum logic [1:0] {IDLE, FETCH, WAIT_ACC, DONE} state_t;
    state_t state, state_nxt;
    logic [IDX_W-1:0] idx, max_idx;
    logic signed [ACC_W-1:0] max_q, sum;
    logic max_valid, hs, last, upd;
`ifdef BIAS_ADD_SAT_EN
    localparam logic signed [ACC_W-1:0] SCORE_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SCORE_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic [ACC_W:0] bias_ext, sum_wide;
    assign bias_ext = {{(ACC_W+1-BIAS_W){bias_i[BIAS_W-1]}}, bias_i} <<< BIAS_SHIFT;
    assign sum_wide = {acc_i[ACC_W-1], acc_i} + bias_ext;
    // The two top bits disagree exactly when the sum left the ACC_W range
    assign sum = (sum_wide[ACC_W] ^ sum_wide[ACC_W-1]) ? (sum_wide[ACC_W] ? SCORE_MIN : SCORE_MAX)
                                                        : sum_wide[ACC_W-1:0];
`else
    logic [ACC_W-1:0] bias_ext;
    // Low ACC_W bits of the wide sum equal a plain ACC_W-bit wrapping add
    assign bias_ext = {{(ACC_W-BIAS_W){bias_i[BIAS_W-1]}}, bias_i} <<< BIAS_SHIFT;
    assign sum = acc_i + bias_ext;
`endif
    assign hs   = acc_valid_i && acc_ready_o;
    assign last = idx == IDX_W'(NUM_CLASSES-1);
    assign upd  = !max_valid || (sum > max_q);
    // State register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state <= IDLE;
        else           state <= state_nxt;
    end
    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = start_i ? FETCH : IDLE;
            FETCH:    state_nxt = WAIT_ACC;
            WAIT_ACC: state_nxt = hs ? (last ? DONE : FETCH) : WAIT_ACC;
            DONE:     state_nxt = result_ready_i ? IDLE : DONE;
            default:  state_nxt = IDLE;
        endcase
    end
    // Status outputs decoded from state
    always_comb begin
        busy_o         = state != IDLE;
        acc_ready_o    = state == WAIT_ACC;
        result_valid_o = state == DONE;
    end
    // Class counter, ROM address, running max and registered result
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            idx        <= '0;
            rom_addr_o <= '0;
            max_q      <= '0;
            max_idx    <= '0;
            max_valid  <= 1'b0;
            class_o    <= '0;
            score_o    <= '0;
        end else if (state == IDLE && start_i) begin
            idx        <= '0;
            rom_addr_o <= '0;
            max_valid  <= 1'b0;
        end else if (hs) begin
            max_valid <= 1'b1;
            if (upd) begin
                max_q   <= sum;
                max_idx <= idx;
            end
            if (last) begin
                class_o <= upd ? idx : max_idx;
                score_o <= upd ? sum : max_q;
            end else begin
                idx        <= idx + 1'b1;
                rom_addr_o <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bias_add_argmax.sv
// tb_bias_add_argmax: directed self-checking bench for bias_add_argmax with a registered bias ROM model.
module tb_bias_add_argmax;
    localparam int N  = 10;
    localparam int IW = 4;
    localparam int AW = 24;
    localparam int BW = 8;
    logic clk_i = 1'b0;
    logic reset_ni = 1'b0;
    logic start_i = 1'b0;
    logic busy_o;
    logic [IW-1:0] rom_addr_o;
    logic signed [BW-1:0] bias_i;
    logic acc_valid_i = 1'b0;
    logic signed [AW-1:0] acc_i = '0;
    logic acc_ready_o;
    logic result_valid_o;
    logic result_ready_i = 1'b0;
    logic [IW-1:0] class_o;
    logic signed [AW-1:0] score_o;
    logic signed [BW-1:0] rom [N];
    logic signed [AW-1:0] acc_tab [N];
    int checks = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    // Registered bias ROM: one cycle read latency
    always_ff @(posedge clk_i) bias_i <= rom[rom_addr_o];

    bias_add_argmax dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i), .busy_o(busy_o),
        .rom_addr_o(rom_addr_o), .bias_i(bias_i), .acc_valid_i(acc_valid_i), .acc_i(acc_i),
        .acc_ready_o(acc_ready_o), .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .class_o(class_o), .score_o(score_o)
    );

    task automatic load_vec1();
        int v [N] = '{5, 3, 9, 1, 0, 2, 9, 4, 7, 6};
        for (int i = 0; i < N; i++) begin
            rom[i] = '0;
            acc_tab[i] = AW'(v[i]);
        end
    endtask

    task automatic load_vec2();
        for (int i = 0; i < N; i++) begin
            rom[i] = (i == 7) ? 8'sd20 : 8'sd0;
            acc_tab[i] = 24'sd10;
        end
    endtask

    task automatic run_frame(input int duty, input int stop_k, input bit chk_lat, input string name);
        int k, n;
        bit hs, prev_stall;
        logic [IW-1:0] pa;
        logic signed [BW-1:0] pb;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        n = 1; k = 0; prev_stall = 0; pa = '0; pb = '0;
        while (!result_valid_o && n < 400 && k != stop_k) begin
            acc_valid_i = $urandom_range(0, 99) < duty;
            acc_i = (k < N) ? acc_tab[k] : '0;
            hs = acc_valid_i && acc_ready_o;
            if (prev_stall) begin
                checks++;
                if (rom_addr_o !== pa || bias_i !== pb)
                    $display("FAIL %s stall_stable: addr=%0d bias=%0d expected addr=%0d bias=%0d", name, rom_addr_o, bias_i, pa, pb);
                if (rom_addr_o !== pa || bias_i !== pb) fails++;
            end
            if (hs) begin
                checks++;
                if (rom_addr_o !== IW'(k)) begin
                    fails++;
                    $display("FAIL %s rom_addr: got %0d expected %0d", name, rom_addr_o, k);
                end
            end
            prev_stall = acc_ready_o && !hs;
            pa = rom_addr_o;
            pb = bias_i;
            @(negedge clk_i);
            n++;
            if (hs) k++;
        end
        acc_valid_i = 1'b0;
        if (stop_k >= N) begin
            checks++;
            if (result_valid_o !== 1'b1) begin
                fails++;
                $display("FAIL %s timeout: result_valid_o=%b expected 1 after %0d cycles", name, result_valid_o, n);
            end
            if (chk_lat) begin
                checks++;
                if (n != 2*N+1) begin
                    fails++;
                    $display("FAIL %s latency: got %0d expected %0d", name, n, 2*N+1);
                end
            end
        end
    endtask

    task automatic check_result(input string name, input logic [IW-1:0] ec, input logic signed [AW-1:0] es);
        checks++;
        if (class_o !== ec) begin
            fails++;
            $display("FAIL %s class: got %0d expected %0d", name, class_o, ec);
        end
        checks++;
        if (score_o !== es) begin
            fails++;
            $display("FAIL %s score: got %0d expected %0d", name, score_o, es);
        end
    endtask

    task automatic take_result(input string name);
        @(negedge clk_i);
        result_ready_i = 1'b1;
        @(negedge clk_i);
        result_ready_i = 1'b0;
        checks++;
        if (result_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            fails++;
            $display("FAIL %s take: valid=%b busy=%b expected 0 0", name, result_valid_o, busy_o);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        checks++;
        if ({busy_o, rom_addr_o, acc_ready_o, result_valid_o, class_o, score_o} !== '0) begin
            fails++;
            $display("FAIL reset: busy=%b addr=%0d rdy=%b valid=%b class=%0d score=%0d expected all 0",
                     busy_o, rom_addr_o, acc_ready_o, result_valid_o, class_o, score_o);
        end
        reset_ni = 1'b1;
    endtask

    task automatic test_tie();
        load_vec1();
        run_frame(100, N, 1, "tie");
        check_result("tie", 4'd2, 24'sd9);
        take_result("tie");
    endtask

    task automatic test_bias();
        load_vec2();
        run_frame(100, N, 1, "bias");
        check_result("bias", 4'd7, 24'sd30);
        take_result("bias");
    endtask

    task automatic test_stall();
        load_vec1();
        run_frame(30, N, 0, "stall");
        check_result("stall", 4'd2, 24'sd9);
        take_result("stall");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < N; i++) begin
            rom[i] = 8'sd1;
            acc_tab[i] = 24'sh7FFFFF;
        end
        run_frame(100, N, 0, "overflow");
`ifdef BIAS_ADD_SAT_EN
        check_result("overflow", 4'd0, 24'sh7FFFFF);
`else
        check_result("overflow", 4'd0, 24'sh800000);
`endif
        take_result("overflow");
    endtask

    task automatic test_hold();
        load_vec1();
        run_frame(100, N, 0, "hold");
        for (int i = 0; i < 10; i++) begin
            start_i = (i % 2) == 0;
            @(negedge clk_i);
            checks++;
            if (result_valid_o !== 1'b1 || busy_o !== 1'b1 || class_o !== 4'd2 || score_o !== 24'sd9) begin
                fails++;
                $display("FAIL hold cycle %0d: valid=%b busy=%b class=%0d score=%0d expected 1 1 2 9",
                         i, result_valid_o, busy_o, class_o, score_o);
            end
        end
        start_i = 1'b0;
        take_result("hold");
        checks++;
        if (class_o !== 4'd2 || score_o !== 24'sd9) begin
            fails++;
            $display("FAIL hold retain: class=%0d score=%0d expected 2 9", class_o, score_o);
        end
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0) begin
            fails++;
            $display("FAIL hold idle: busy=%b expected 0", busy_o);
        end
    endtask

    task automatic test_abort();
        load_vec2();
        run_frame(100, 4, 0, "abort");
        #2 reset_ni = 1'b0;
        #1;
        checks++;
        if ({busy_o, rom_addr_o, acc_ready_o, result_valid_o, class_o, score_o} !== '0) begin
            fails++;
            $display("FAIL abort async: busy=%b addr=%0d rdy=%b valid=%b class=%0d score=%0d expected all 0",
                     busy_o, rom_addr_o, acc_ready_o, result_valid_o, class_o, score_o);
        end
        @(negedge clk_i);
        reset_ni = 1'b1;
        run_frame(100, N, 1, "after_abort");
        check_result("after_abort", 4'd7, 24'sd30);
        take_result("after_abort");
    endtask

    initial begin
        test_reset();
        test_tie();
        test_bias();
        test_stall();
        test_overflow();
        test_hold();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
